outport_fifo_tx: RTL and testbench
==================================

// Module: outport_fifo_tx
// PURPOSE
//  Output-port peripheral for the `out` instruction, mirroring the input port on the datapath bus.
//  When the control unit asserts outport_enable, the block captures the 32-bit bus word into a FIFO.
//  It then presents each word to an external consumer with a valid/ready handshake.
//  CPU writes never stall; the full and overflow flags report back-pressure to the control unit.
// PARAMETERS
//  DATA_W   32  bus/word width
//  DEPTH     4  FIFO entries, power of 2, >=2
//  CNT_W     3  count width = log2(DEPTH)+1
// PORTS
//  clk            in   1      system clock, all logic on posedge
//  clr            in   1      reset, synchronous, active-low
//  outport_enable in   1      capture bus_in this cycle (out instruction, T3)
//  bus_in         in   DATA_W datapath bus
//  ext_data       out  DATA_W word offered to consumer (registered)
//  ext_valid      out  1      ext_data valid
//  ext_ready      in   1      consumer accepts when ext_valid&ext_ready
//  fifo_full      out  1      count==DEPTH
//  fifo_empty     out  1      count==0 and output stage idle
//  fifo_count     out  CNT_W  words held in FIFO (excl. output stage)
//  overflow       out  1      sticky: a write was dropped
// BEHAVIOUR
//  Reset (clr==0 at posedge): ptrs/count=0, ext_valid=0, ext_data=0, overflow=0, state=IDLE; fifo_empty=1, fifo_full=0.
//  Push: on outport_enable, bus_in is written at wr_ptr when !fifo_full, or when fifo_full and a FIFO pop occurs in the same cycle.
//  Pushes that meet neither condition are dropped and set overflow; overflow clears only on reset.
//  Pointers wrap modulo DEPTH; count += push - pop and stays in 0..DEPTH.
//  Output FSM, 2 states:
//   IDLE: ext_valid=0. If the FIFO is non-empty, pop the head into ext_data and go to SEND.
//         If the FIFO is empty and outport_enable, load bus_in straight into ext_data (bypass, no FIFO write) and go to SEND.
//   SEND: ext_valid=1 and ext_data held stable.
//         On ext_ready with the FIFO non-empty: load the head, stay in SEND (back-to-back, 1 word/cycle).
//         On ext_ready with the FIFO empty and a same-cycle push: load bus_in, stay in SEND.
//         On ext_ready with neither: go to IDLE.
//  Latency: push into the empty block -> ext_valid=1 on the next posedge (1 cycle).
//  Throughput: 1 word/cycle sustained with ext_ready held high.
//  Words are delivered in push order; none are duplicated or lost unless overflow is set.
//  Capacity: DEPTH + 1 words (FIFO plus output stage).
//  ext_ready while ext_valid==0 is ignored.
//  Reset mid-transfer: the held word and all FIFO contents are discarded; ext_valid=0 on the cycle after the reset edge.
//  fifo_full, fifo_empty and fifo_count are combinational from registered state.
// CONFIGURATION
//  OUTPORT_PARITY_EN defined:
//   - adds output ext_parity (1 bit) = ^ext_data (even parity).
//   - ext_parity is registered with ext_data and is 0 at reset.
//  OUTPORT_PARITY_EN undefined: port and logic are absent; all other behaviour is identical.
// STRUCTURE
//  Shared package outport_pkg: DATA_W default, OUT_IDLE/OUT_SEND state encoding, parity function.
//  Sub-module sync_fifo: storage, pointers, count, full/empty.
//   - Its write qualifier and overflow detection remain in outport_fifo_tx.
//  outport_fifo_tx itself holds the output FSM, bypass mux, and the overflow flag.
// TESTING
//  1 Reset: hold clr=0 for 2 cycles -> ext_valid=0, ext_data=0, fifo_empty=1, fifo_count=0, overflow=0.
//  2 Single word, ready=1: push 32'h00000021 -> next cycle ext_valid=1, ext_data=32'h21; the following cycle ext_valid=0, fifo_empty=1.
//  3 Fill with ready=0: push 1..6 on consecutive cycles -> ext_data=1, fifo_count=4, fifo_full=1, overflow=1 (word 6 dropped).
//    Then ready=1 -> words 1,2,3,4,5 on 5 consecutive cycles.
//  4 Full with simultaneous push/pop: FIFO full, ext_ready=1, push 32'hA5A5A5A5 -> accepted, overflow stays 0, fifo_count stays 4.
//  5 Back-pressure: ext_valid=1 with ext_ready toggling 0/1 -> ext_data stable while ready=0; order preserved; no duplicates.
//  6 Reset mid-transfer: 3 words queued, clr=0 for one cycle -> ext_valid=0, count=0; a new push 32'h7 is the next word out.
//    With OUTPORT_PARITY_EN: ext_parity=1 for 32'h7.

Source files
------------

// File: rtl/outport_pkg.sv
// ============================================================================
// Module : outport_pkg
// Shared width default, output FSM encoding and parity helper for outport_fifo_tx.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package outport_pkg;

    localparam int OUT_DATA_W = 32;

    localparam logic [0:0] OUT_IDLE = 1'b0;
    localparam logic [0:0] OUT_SEND = 1'b1;

    function automatic logic even_parity(input logic [OUT_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/outport_fifo_tx_sync_fifo.sv
// ============================================================================
// Module : sync_fifo
// Storage, wrapping pointers, occupancy count and full/empty for outport_fifo_tx.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full,
    output logic              o_empty
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    // Caller guarantees no pop when empty and no push when full without a pop.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (i_pop && !i_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == c_DEPTH);
    assign o_empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/outport_fifo_tx.sv
// ============================================================================
// Module : outport_fifo_tx
// Output port: buffers bus words in a FIFO and streams them over valid/ready.
// Optional feature macro: OUTPORT_PARITY_EN (adds registered ext_parity).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module outport_fifo_tx
    import outport_pkg::*;
#(
    parameter int DATA_W = OUT_DATA_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              outport_enable,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] ext_data,
    output logic              ext_valid,
    input  logic              ext_ready,
`ifdef OUTPORT_PARITY_EN
    output logic              ext_parity,
`endif
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              overflow
);

    logic [0:0]        r_state;
    logic [DATA_W-1:0] r_ext_data;
    logic              r_overflow;

    logic [DATA_W-1:0] w_head;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_bypass;
    logic              w_push;
    logic              w_drop;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .clr     (clr),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (bus_in),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Output stage refills from the FIFO head first; bus_in bypasses only when the FIFO is empty.
    always_comb begin
        w_pop    = 1'b0;
        w_bypass = 1'b0;
        case (r_state)
            OUT_IDLE: begin
                if (!w_empty)            w_pop    = 1'b1;
                else if (outport_enable) w_bypass = 1'b1;
            end
            OUT_SEND: begin
                if (ext_ready) begin
                    if (!w_empty)            w_pop    = 1'b1;
                    else if (outport_enable) w_bypass = 1'b1;
                end
            end
            default: ;
        endcase
        w_push = outport_enable && !w_bypass && (!w_full || w_pop);
        w_drop = outport_enable && !w_bypass && !w_push;
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state    <= OUT_IDLE;
            r_ext_data <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop || w_bypass) begin
                r_state    <= OUT_SEND;
                r_ext_data <= w_pop ? w_head : bus_in;
            end else if (r_state == OUT_SEND && ext_ready) begin
                r_state <= OUT_IDLE;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef OUTPORT_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_parity <= 1'b0;
        end else if (w_pop || w_bypass) begin
            r_parity <= even_parity(w_pop ? w_head : bus_in);
        end
    end

    assign ext_parity = r_parity;
`endif

    assign ext_data   = r_ext_data;
    assign ext_valid  = (r_state == OUT_SEND);
    assign overflow   = r_overflow;
    assign fifo_full  = w_full;
    assign fifo_count = w_count;
    assign fifo_empty = w_empty && (r_state == OUT_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_outport_fifo_tx.sv
// ============================================================================
// Module : tb_outport_fifo_tx
// Directed self-checking bench for outport_fifo_tx.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_outport_fifo_tx;

    logic        clk = 1'b0;
    logic        clr;
    logic        outport_enable;
    logic [31:0] bus_in;
    logic [31:0] ext_data;
    logic        ext_valid;
    logic        ext_ready;
`ifdef OUTPORT_PARITY_EN
    logic        ext_parity;
`endif
    logic        fifo_full;
    logic        fifo_empty;
    logic [2:0]  fifo_count;
    logic        overflow;

    int n_chk  = 0;
    int n_fail = 0;

    outport_fifo_tx dut (
        .clk            (clk),
        .clr            (clr),
        .outport_enable (outport_enable),
        .bus_in         (bus_in),
        .ext_data       (ext_data),
        .ext_valid      (ext_valid),
        .ext_ready      (ext_ready),
`ifdef OUTPORT_PARITY_EN
        .ext_parity     (ext_parity),
`endif
        .fifo_full      (fifo_full),
        .fifo_empty     (fifo_empty),
        .fifo_count     (fifo_count),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        outport_enable = 1'b1;
        bus_in         = w;
        tick();
        outport_enable = 1'b0;
    endtask

    initial begin
        clr = 1'b0; outport_enable = 1'b0; bus_in = '0; ext_ready = 1'b0;

        // 1 reset
        tick(); tick();
        chk("rst_valid", {31'b0, ext_valid}, 32'd0);
        chk("rst_data", ext_data, 32'd0);
        chk("rst_empty", {31'b0, fifo_empty}, 32'd1);
        chk("rst_full", {31'b0, fifo_full}, 32'd0);
        chk("rst_count", {29'b0, fifo_count}, 32'd0);
        chk("rst_ovf", {31'b0, overflow}, 32'd0);
        clr = 1'b1;
        tick();

        // 2 single word with ready high
        ext_ready = 1'b1;
        push(32'h21);
        chk("t2_valid", {31'b0, ext_valid}, 32'd1);
        chk("t2_data", ext_data, 32'h21);
        tick();
        chk("t2_idle", {31'b0, ext_valid}, 32'd0);
        chk("t2_empty", {31'b0, fifo_empty}, 32'd1);

        // 3 fill with ready low, word 6 dropped
        ext_ready = 1'b0;
        for (int i = 1; i <= 6; i++) push(i);
        chk("t3_data", ext_data, 32'd1);
        chk("t3_count", {29'b0, fifo_count}, 32'd4);
        chk("t3_full", {31'b0, fifo_full}, 32'd1);
        chk("t3_ovf", {31'b0, overflow}, 32'd1);
        chk("t3_empty", {31'b0, fifo_empty}, 32'd0);
        ext_ready = 1'b1;
        chk("t3_w1", ext_data, 32'd1);
        for (int k = 2; k <= 5; k++) begin
            tick();
            chk("t3_drain_valid", {31'b0, ext_valid}, 32'd1);
            chk("t3_drain", ext_data, k);
        end
        chk("t3_cnt0", {29'b0, fifo_count}, 32'd0);
        tick();
        chk("t3_end_valid", {31'b0, ext_valid}, 32'd0);
        chk("t3_end_empty", {31'b0, fifo_empty}, 32'd1);

        // 4 full with simultaneous push and pop (reset first to clear overflow)
        clr = 1'b0; tick(); clr = 1'b1;
        chk("t4_ovf_clr", {31'b0, overflow}, 32'd0);
        ext_ready = 1'b0;
        for (int i = 10; i <= 14; i++) push(i);
        chk("t4_full", {31'b0, fifo_full}, 32'd1);
        ext_ready = 1'b1;
        push(32'hA5A5A5A5);
        chk("t4_ovf", {31'b0, overflow}, 32'd0);
        chk("t4_count", {29'b0, fifo_count}, 32'd4);
        chk("t4_data", ext_data, 32'd11);
        tick(); chk("t4_d12", ext_data, 32'd12);
        tick(); chk("t4_d13", ext_data, 32'd13);
        tick(); chk("t4_d14", ext_data, 32'd14);
        tick(); chk("t4_dA5", ext_data, 32'hA5A5A5A5);
        chk("t4_vA5", {31'b0, ext_valid}, 32'd1);
        tick();
        chk("t4_idle", {31'b0, ext_valid}, 32'd0);

        // 5 back-pressure with ready toggling
        ext_ready = 1'b0;
        push(32'd20); push(32'd21); push(32'd22);
        tick(); chk("t5_hold20", ext_data, 32'd20);
        ext_ready = 1'b1; tick(); chk("t5_d21", ext_data, 32'd21);
        ext_ready = 1'b0; tick(); chk("t5_hold21", ext_data, 32'd21);
        ext_ready = 1'b1; tick(); chk("t5_d22", ext_data, 32'd22);
        ext_ready = 1'b0; tick(); chk("t5_hold22", ext_data, 32'd22);
        chk("t5_v22", {31'b0, ext_valid}, 32'd1);
        ext_ready = 1'b1; tick();
        chk("t5_idle", {31'b0, ext_valid}, 32'd0);
        chk("t5_empty", {31'b0, fifo_empty}, 32'd1);

        // 6 reset mid-transfer
        ext_ready = 1'b0;
        push(32'd30); push(32'd31); push(32'd32);
        chk("t6_cnt2", {29'b0, fifo_count}, 32'd2);
        clr = 1'b0; tick(); clr = 1'b1;
        chk("t6_valid", {31'b0, ext_valid}, 32'd0);
        chk("t6_count", {29'b0, fifo_count}, 32'd0);
        chk("t6_empty", {31'b0, fifo_empty}, 32'd1);
        chk("t6_data", ext_data, 32'd0);
        push(32'h7);
        chk("t6_v7", {31'b0, ext_valid}, 32'd1);
        chk("t6_d7", ext_data, 32'h7);
`ifdef OUTPORT_PARITY_EN
        chk("t6_par", {31'b0, ext_parity}, 32'd1);
`endif
        ext_ready = 1'b1; tick();
        chk("t6_idle", {31'b0, ext_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
